// File: rtl/lgdst_rxglue_pkg.sv
// Shared constants and helpers for the lgdst_rxglue SPI-to-TS receive glue.
package lgdst_rxglue_pkg;

  localparam int       BYTE_W           = 8;
  localparam logic     IDLE_BIT_DEFAULT = 1'b0;
  localparam logic [2:0] TS_IDX_RST     = 3'd7;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/lgdst_rxglue_fifo.sv
// Byte FIFO with wrap-bit pointers; a push while full is honoured only when a pop frees a slot.
// Level and drop outputs exist only when LGDST_RXGLUE_STATUS_EN is defined.
module lgdst_rxglue_fifo
  import lgdst_rxglue_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [BYTE_W-1:0] push_data,
  input  logic              pop,
  output logic [BYTE_W-1:0] head_data,
  output logic              empty
`ifdef LGDST_RXGLUE_STATUS_EN
  ,
  output logic [ptr_width(DEPTH)-1:0] level,
  output logic                        dropped
`endif
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int AW    = PTR_W - 1;

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic              full, pop_ok, push_ok;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  assign head_data = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q + PTR_W'(push_ok);
    rd_d = rd_q + PTR_W'(pop_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= push_data;
  end

`ifdef LGDST_RXGLUE_STATUS_EN
  assign level   = wr_q - rd_q;
  assign dropped = push & ~push_ok;
`endif

endmodule

// File: rtl/lgdst_rxglue.sv
// SPI write-only byte receiver feeding a FIFO that is drained bit-serially onto ts_d0.
// Define LGDST_RXGLUE_STATUS_EN to expose fifo_level, ovf_sticky and unf_sticky.
module lgdst_rxglue
  import lgdst_rxglue_pkg::*;
#(
  parameter int   FIFO_DEPTH  = 16,
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_BIT    = IDLE_BIT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic spi_clk,
  input  logic spi_cs,
  input  logic spi_mosi,
  input  logic ts_clk,
  input  logic ts_valid,
  input  logic ts_sync,
  output logic ts_d0
`ifdef LGDST_RXGLUE_STATUS_EN
  ,
  output logic [ptr_width(FIFO_DEPTH)-1:0] fifo_level,
  output logic                             ovf_sticky,
  output logic                             unf_sticky
`endif
);

  localparam int             NSYNC    = 6;
  // Chip select idles high, so its synchronizer chain resets to 1.
  localparam logic [NSYNC-1:0] SYNC_RST = 6'b000010;

  logic [SYNC_STAGES-1:0][NSYNC-1:0] sync_q, sync_d;
  logic spi_clk_s, cs_s, mosi_s, ts_clk_s, valid_s, tsync_s;
  logic spi_prev_q, spi_prev_d, ts_prev_q, ts_prev_d;
  logic spi_rise, ts_rise;

  logic [BYTE_W-1:0] shift_q, shift_d, push_byte;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d, idx_eff;
  logic              d0_q, d0_d;
  logic              push, pop, fifo_empty;
  logic [BYTE_W-1:0] head_data;

  always_comb begin
    sync_d[0] = {ts_sync, ts_valid, ts_clk, spi_mosi, spi_cs, spi_clk};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  assign {tsync_s, valid_s, ts_clk_s, mosi_s, cs_s, spi_clk_s} = sync_q[SYNC_STAGES-1];
  assign spi_rise = spi_clk_s & ~spi_prev_q;
  assign ts_rise  = ts_clk_s & ~ts_prev_q;
  assign ts_d0    = d0_q;

  always_comb begin
    spi_prev_d = spi_clk_s;
    ts_prev_d  = ts_clk_s;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    push       = 1'b0;
    push_byte  = {shift_q[BYTE_W-2:0], mosi_s};
    idx_d      = idx_q;
    idx_eff    = idx_q;
    d0_d       = d0_q;
    pop        = 1'b0;

    // Deasserted chip select discards any partial byte.
    if (cs_s) begin
      cnt_d = 3'd0;
    end else if (spi_rise) begin
      shift_d = push_byte;
      cnt_d   = cnt_q + 3'd1;
      push    = (cnt_q == 3'd7);
    end

    if (ts_rise && valid_s) begin
      idx_eff = tsync_s ? TS_IDX_RST : idx_q;
      if (!fifo_empty) begin
        d0_d = head_data[idx_eff];
        if (idx_eff == 3'd0) begin
          pop   = 1'b1;
          idx_d = TS_IDX_RST;
        end else begin
          idx_d = idx_eff - 3'd1;
        end
      end else begin
        d0_d  = IDLE_BIT;
        idx_d = TS_IDX_RST;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q     <= {SYNC_STAGES{SYNC_RST}};
      spi_prev_q <= 1'b0;
      ts_prev_q  <= 1'b0;
      shift_q    <= '0;
      cnt_q      <= 3'd0;
      idx_q      <= TS_IDX_RST;
      d0_q       <= IDLE_BIT;
    end else begin
      sync_q     <= sync_d;
      spi_prev_q <= spi_prev_d;
      ts_prev_q  <= ts_prev_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      d0_q       <= d0_d;
    end
  end

`ifdef LGDST_RXGLUE_STATUS_EN
  logic [ptr_width(FIFO_DEPTH)-1:0] level;
  logic dropped, ovf_q, ovf_d, unf_q, unf_d;

  always_comb begin
    ovf_d = ovf_q | dropped;
    unf_d = unf_q | (ts_rise & valid_s & fifo_empty);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign fifo_level = level;
  assign ovf_sticky = ovf_q;
  assign unf_sticky = unf_q;
`endif

  lgdst_rxglue_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (push),
    .push_data (push_byte),
    .pop       (pop),
    .head_data (head_data),
    .empty     (fifo_empty)
`ifdef LGDST_RXGLUE_STATUS_EN
    ,
    .level     (level),
    .dropped   (dropped)
`endif
  );

endmodule

// File: tb/tb_lgdst_rxglue.sv
// Directed + randomized bench for lgdst_rxglue against a byte-queue reference model.
// Status-port checks are compiled in when LGDST_RXGLUE_STATUS_EN is defined.
module tb_lgdst_rxglue;

  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic reset, spi_clk, spi_cs, spi_mosi, ts_clk, ts_valid, ts_sync;
  logic ts_d0;
`ifdef LGDST_RXGLUE_STATUS_EN
  logic [LW-1:0] fifo_level;
  logic ovf_sticky, unf_sticky;
`endif

  lgdst_rxglue #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2), .IDLE_BIT(1'b0)) dut (
    .clk      (clk),
    .reset    (reset),
    .spi_clk  (spi_clk),
    .spi_cs   (spi_cs),
    .spi_mosi (spi_mosi),
    .ts_clk   (ts_clk),
    .ts_valid (ts_valid),
    .ts_sync  (ts_sync),
    .ts_d0    (ts_d0)
`ifdef LGDST_RXGLUE_STATUS_EN
    ,
    .fifo_level (fifo_level),
    .ovf_sticky (ovf_sticky),
    .unf_sticky (unf_sticky)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: queue of whole bytes plus how many bits of the head are already out.
  logic [7:0] mq[$];
  int         consumed;
  logic       exp_d0;
  logic       ovf_m, unf_m;
  int         tests, fails;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    consumed = 0;
    exp_d0   = 1'b0;
    ovf_m    = 1'b0;
    unf_m    = 1'b0;
  endtask

  task automatic spi_bit(input logic b);
    @(negedge clk);
    spi_mosi = b;
    repeat (3) @(negedge clk);
    spi_clk = 1'b1;
    repeat (4) @(negedge clk);
    spi_clk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic set_cs(input logic v);
    @(negedge clk);
    spi_cs = v;
    repeat (4) @(negedge clk);
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
    if (mq.size() < DEPTH) mq.push_back(b);
    else ovf_m = 1'b1;
    $display("[TB] spi byte %02h sent, model depth %0d", b, mq.size());
  endtask

  task automatic ts_req(input logic v, input logic s, input string tag);
    @(negedge clk);
    ts_valid = v;
    ts_sync  = s;
    repeat (3) @(negedge clk);
    ts_clk = 1'b1;
    repeat (4) @(negedge clk);
    ts_clk = 1'b0;
    repeat (3) @(negedge clk);
    if (v) begin
      if (s) consumed = 0;
      if (mq.size() == 0) begin
        exp_d0   = 1'b0;
        consumed = 0;
        unf_m    = 1'b1;
      end else begin
        exp_d0 = mq[0][7 - consumed];
        consumed++;
        if (consumed == 8) begin
          void'(mq.pop_front());
          consumed = 0;
        end
      end
    end
    check(tag, {31'd0, ts_d0}, {31'd0, exp_d0});
  endtask

  task automatic ts_drain_byte(input logic s_first, input string tag);
    for (int i = 0; i < 8; i++) ts_req(1'b1, s_first && (i == 0), tag);
    $display("[TB] ts byte drained (%s), model depth %0d", tag, mq.size());
  endtask

  task automatic check_status(input string tag);
`ifdef LGDST_RXGLUE_STATUS_EN
    check({tag, "_level"}, {{(32-LW){1'b0}}, fifo_level}, mq.size());
    check({tag, "_ovf"}, {31'd0, ovf_sticky}, {31'd0, ovf_m});
    check({tag, "_unf"}, {31'd0, unf_sticky}, {31'd0, unf_m});
`else
    $display("[TB] status point %s (status ports not built)", tag);
`endif
  endtask

  initial begin
    tests = 0;
    fails = 0;
    model_reset();
    reset = 1'b1; spi_clk = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0;
    ts_clk = 1'b0; ts_valid = 1'b0; ts_sync = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_d0", {31'd0, ts_d0}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("post_reset_d0", {31'd0, ts_d0}, 32'd0);
    check_status("reset");

    // spi_clk toggles with chip select high must be ignored.
    for (int i = 0; i < 20; i++) spi_bit(i[0]);
    ts_drain_byte(1'b1, "cs_high_idle");

    set_cs(1'b0);
    spi_byte(8'hAF);
    spi_byte(8'hF1);
    spi_byte(8'h34);
    spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1);
    set_cs(1'b1);
    check_status("three_bytes");
    ts_drain_byte(1'b1, "drain_AF");
    ts_drain_byte(1'b0, "drain_F1");
    ts_drain_byte(1'b0, "drain_34");
    ts_drain_byte(1'b0, "partial_dropped");

    // Realignment: sync on the 4th request restarts 0xA5 from bit 7.
    set_cs(1'b0);
    spi_byte(8'hA5);
    spi_byte(8'h3C);
    set_cs(1'b1);
    for (int i = 0; i < 3; i++) ts_req(1'b1, 1'b0, "a5_pre");
    ts_req(1'b1, 1'b1, "a5_resync");
    for (int i = 0; i < 7; i++) ts_req(1'b1, 1'b0, "a5_rest");
    ts_drain_byte(1'b0, "drain_3C");
    ts_req(1'b0, 1'b0, "hold_no_valid");

    // Overflow: two pushes beyond capacity are dropped.
    set_cs(1'b0);
    for (int i = 0; i < DEPTH + 2; i++) spi_byte(8'($urandom));
    set_cs(1'b1);
    check_status("overflow");
    for (int i = 0; i < DEPTH + 1; i++) ts_drain_byte(1'b0, "ovf_drain");

    // Randomized interleave of SPI bytes and TS requests.
    for (int r = 0; r < 12; r++) begin
      set_cs(1'b0);
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) spi_byte(8'($urandom));
      set_cs(1'b1);
      for (int k = 0; k < int'($urandom_range(4, 20)); k++)
        ts_req(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) == 0), "rand_ts");
    end
    check_status("random");

    // Asynchronous reset in the middle of a TS byte and an SPI byte.
    ts_drain_byte(1'b1, "pre_reset_flush");
    for (int k = 0; k < DEPTH + 1; k++) ts_drain_byte(1'b0, "pre_reset_flush");
    set_cs(1'b0);
    spi_byte(8'hA5);
    set_cs(1'b1);
    for (int i = 0; i < 3; i++) ts_req(1'b1, (i == 0), "pre_reset_bits");
    set_cs(1'b0);
    spi_bit(1'b1); spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check("async_reset_d0", {31'd0, ts_d0}, 32'd0);
    model_reset();
    check_status("async_reset");
    spi_cs = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    ts_req(1'b1, 1'b0, "after_reset_empty");
    set_cs(1'b0);
    spi_byte(8'h47);
    set_cs(1'b1);
    ts_drain_byte(1'b1, "drain_47");
    ts_req(1'b1, 1'b0, "final_idle");
    check_status("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
